// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: latches a MEM-stage request, waits LATENCY
// cycles, commits the access, and stalls the pipeline until the done pulse.
module data_mem_responder #(
  parameter int unsigned LATENCY = 2,
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned ADDR_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_enable,
  input  logic              req_rw,
  input  logic              req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic [31:0]       rdata,
  output logic              done,
  output logic              error,
  output logic              stall
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              rw_q, rw_d;
  logic              size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              error_q, error_d;
  logic              commit;

  logic [7:0] mem [0:DEPTH-1];

  // Word accesses are aligned, so the byte lanes are formed by replacing
  // the low two address bits rather than by addition (no wrap possible).
  logic [ADDR_W-1:0] a0, a1, a2, a3;
  assign a0 = {addr_q[ADDR_W-1:2], 2'b00};
  assign a1 = {addr_q[ADDR_W-1:2], 2'b01};
  assign a2 = {addr_q[ADDR_W-1:2], 2'b10};
  assign a3 = {addr_q[ADDR_W-1:2], 2'b11};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    error_d = error_q;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_enable) begin
          rw_d    = req_rw;
          size_d  = req_size;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = 4'(LATENCY);
          if (req_size && (req_addr[1:0] != 2'b00)) begin
            state_d = S_RESP;
            error_d = 1'b1;
            rdata_d = '0;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          commit  = 1'b1;
          state_d = S_RESP;
          error_d = 1'b0;
          if (rw_q)        rdata_d = '0;
          else if (size_q) rdata_d = {mem[a0], mem[a1], mem[a2], mem[a3]};
          else             rdata_d = {24'b0, mem[addr_q]};
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        error_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      size_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
    end
  end

  // Storage is never cleared; a reset on the commit edge drops the write.
  always_ff @(posedge clk) begin
    if (reset && commit && rw_q) begin
      if (size_q) begin
        mem[a0] <= wdata_q[31:24];
        mem[a1] <= wdata_q[23:16];
        mem[a2] <= wdata_q[15:8];
        mem[a3] <= wdata_q[7:0];
      end else begin
        mem[addr_q] <= wdata_q[7:0];
      end
    end
  end

  assign rdata = rdata_q;
  assign error = error_q;
  assign done  = (state_q == S_RESP);
  assign stall = ((state_q == S_IDLE) && req_enable) || (state_q == S_WAIT);

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: table of single accesses on a
// LATENCY=2 instance plus reset, back-to-back and LATENCY=1 sequences.
module tb_data_mem_responder;

  logic        clk;
  logic        rst_n;
  logic        req_enable, req_rw, req_size;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic [31:0] rdata;
  logic        done, error, stall;

  logic        r1_enable, r1_rw, r1_size;
  logic [7:0]  r1_addr;
  logic [31:0] r1_wdata;
  logic [31:0] r1_rdata;
  logic        r1_done, r1_error, r1_stall;

  int errors = 0;
  int checks = 0;

  data_mem_responder #(.LATENCY(2), .DEPTH(256), .ADDR_W(8)) dut (
    .clk(clk), .reset(rst_n), .req_enable(req_enable), .req_rw(req_rw),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .rdata(rdata), .done(done), .error(error), .stall(stall)
  );

  data_mem_responder #(.LATENCY(1), .DEPTH(256), .ADDR_W(8)) dut1 (
    .clk(clk), .reset(rst_n), .req_enable(r1_enable), .req_rw(r1_rw),
    .req_size(r1_size), .req_addr(r1_addr), .req_wdata(r1_wdata),
    .rdata(r1_rdata), .done(r1_done), .error(r1_error), .stall(r1_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    string       name;
    logic        rw;
    logic        size;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_done;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", nm, got, exp);
    end
  endtask

  // Called at posedge+1 with dut idle; returns after the edge following done.
  task automatic do_req(input logic rw, input logic size, input logic [7:0] addr,
                        input logic [31:0] wd, output int done_cyc, output int stall_cnt,
                        output logic [31:0] rd, output logic er);
    req_enable = 1'b1; req_rw = rw; req_size = size; req_addr = addr; req_wdata = wd;
    done_cyc = -1; stall_cnt = 0; rd = 'x; er = 1'bx;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (stall) stall_cnt++;
      if (done) begin done_cyc = c; rd = rdata; er = error; end
      @(posedge clk); #1;
      if (done_cyc >= 0) break;
    end
    req_enable = 1'b0;
  endtask

  initial begin
    int          dc, sc, ndone;
    int          dcyc [4];
    logic [31:0] rd;
    logic        er;

    vecs[0]  = '{"w_word_10",  1'b1, 1'b1, 8'h10, 32'hDEADBEEF, 32'h0,        1'b0, 3};
    vecs[1]  = '{"r_word_10",  1'b0, 1'b1, 8'h10, 32'h0,        32'hDEADBEEF, 1'b0, 3};
    vecs[2]  = '{"w_byte_13",  1'b1, 1'b0, 8'h13, 32'h000000AA, 32'h0,        1'b0, 3};
    vecs[3]  = '{"r_byte_13",  1'b0, 1'b0, 8'h13, 32'h0,        32'h000000AA, 1'b0, 3};
    vecs[4]  = '{"r_word_10b", 1'b0, 1'b1, 8'h10, 32'h0,        32'hDEADBEAA, 1'b0, 3};
    vecs[5]  = '{"r_mis_22",   1'b0, 1'b1, 8'h22, 32'h0,        32'h0,        1'b1, 1};
    vecs[6]  = '{"r_byte_23",  1'b0, 1'b0, 8'h23, 32'h0,        32'h00000079, 1'b0, 3};
    vecs[7]  = '{"w_mis_21",   1'b1, 1'b1, 8'h21, 32'h55555555, 32'h0,        1'b1, 1};
    vecs[8]  = '{"r_word_20",  1'b0, 1'b1, 8'h20, 32'h0,        32'h7A7B7879, 1'b0, 3};
    vecs[9]  = '{"w_byte_7f",  1'b1, 1'b0, 8'h7F, 32'h123456C3, 32'h0,        1'b0, 3};
    vecs[10] = '{"r_word_7c",  1'b0, 1'b1, 8'h7C, 32'h0,        32'h262724C3, 1'b0, 3};

    for (int i = 0; i < 256; i++) begin
      dut.mem[i]  <= 8'(i) ^ 8'h5A;
      dut1.mem[i] <= 8'(i) ^ 8'h5A;
    end
    dut1.mem[8'hFC] <= 8'h01;
    dut1.mem[8'hFD] <= 8'h02;
    dut1.mem[8'hFE] <= 8'h03;
    dut1.mem[8'hFF] <= 8'h04;
    dut1.mem[8'h00] <= 8'hEE;

    rst_n = 1'b0;
    req_enable = 1'b0; req_rw = 1'b0; req_size = 1'b0; req_addr = '0; req_wdata = '0;
    r1_enable = 1'b0; r1_rw = 1'b0; r1_size = 1'b0; r1_addr = '0; r1_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rdata", rdata, 32'h0);
    check("reset_done",  {31'b0, done},  32'h0);
    check("reset_error", {31'b0, error}, 32'h0);
    check("reset_stall", {31'b0, stall}, 32'h0);
    req_enable = 1'b1;
    #1;
    check("idle_stall_follows_req", {31'b0, stall}, 32'h1);
    req_enable = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    repeat (3) begin
      @(posedge clk); #1;
      check("idle_no_done",  {31'b0, done},  32'h0);
      check("idle_no_stall", {31'b0, stall}, 32'h0);
    end

    for (int i = 0; i < 11; i++) begin
      do_req(vecs[i].rw, vecs[i].size, vecs[i].addr, vecs[i].wdata, dc, sc, rd, er);
      check({vecs[i].name, "_done_cycle"}, 32'(dc), 32'(vecs[i].exp_done));
      check({vecs[i].name, "_stall_cycles"}, 32'(sc), 32'(vecs[i].exp_done));
      check({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rdata);
      check({vecs[i].name, "_error"}, {31'b0, er}, {31'b0, vecs[i].exp_err});
    end

    check("mem_10", {24'b0, dut.mem[8'h10]}, 32'hDE);
    check("mem_11", {24'b0, dut.mem[8'h11]}, 32'hAD);
    check("mem_12", {24'b0, dut.mem[8'h12]}, 32'hBE);
    check("mem_13", {24'b0, dut.mem[8'h13]}, 32'hAA);
    check("mem_24_untouched", {24'b0, dut.mem[8'h24]}, 32'h7E);

    // Reset asserted during the first WAIT cycle of a word write.
    req_enable = 1'b1; req_rw = 1'b1; req_size = 1'b1; req_addr = 8'h40; req_wdata = 32'h12345678;
    @(posedge clk); #1;
    rst_n = 1'b0; req_enable = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("midrst_rdata", rdata, 32'h0);
    check("midrst_done",  {31'b0, done},  32'h0);
    check("midrst_error", {31'b0, error}, 32'h0);
    check("midrst_stall", {31'b0, stall}, 32'h0);
    ndone = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("midrst_no_done", 32'(ndone), 32'h0);
    check("midrst_mem_40", {24'b0, dut.mem[8'h40]}, 32'h1A);
    check("midrst_mem_41", {24'b0, dut.mem[8'h41]}, 32'h1B);
    check("midrst_mem_42", {24'b0, dut.mem[8'h42]}, 32'h18);
    check("midrst_mem_43", {24'b0, dut.mem[8'h43]}, 32'h19);

    // Back-to-back: request held high through RESP.
    req_enable = 1'b1; req_rw = 1'b0; req_size = 1'b1; req_addr = 8'h10; req_wdata = '0;
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      if (c == 8) req_enable = 1'b0;
      #1;
      if (done) begin
        if (ndone < 4) dcyc[ndone] = c;
        ndone++;
        check("b2b_rdata", rdata, 32'hDEADBEAA);
      end
      @(posedge clk); #1;
    end
    check("b2b_done_count", 32'(ndone), 32'd2);
    if (ndone >= 2) begin
      check("b2b_first_done",  32'(dcyc[0]), 32'd3);
      check("b2b_second_done", 32'(dcyc[1]), 32'd7);
    end

    // LATENCY=1 instance: aligned word at the top of memory.
    r1_enable = 1'b1; r1_rw = 1'b0; r1_size = 1'b1; r1_addr = 8'hFC;
    dc = -1; rd = 'x;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (r1_done) begin dc = c; rd = r1_rdata; end
      @(posedge clk); #1;
      if (dc >= 0) break;
    end
    r1_enable = 1'b0;
    check("lat1_done_cycle", 32'(dc), 32'd2);
    check("lat1_rdata", rd, 32'h01020304);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Multi-cycle data-memory responder on the memory side of the pipeline's MEM-stage request interface (enable, read/write, size, address, store data). It latches each request, waits a fixed latency, commits the write or drives the read data, and stalls the pipeline until the access completes. It replaces the zero-latency combinational data RAM so the hazard unit and the pipeline registers can be exercised against a realistic memory.

## Interface
- LATENCY, 2: wait cycles between request capture and access commit; legal range 1–15.
- DEPTH, 256: memory size in bytes.
- ADDR_W, 8: byte-address width; DEPTH = 2**ADDR_W.
- clk  in  1  system clock; rising edge.
- reset  in  1  synchronous, active-low reset.
- req_enable  in  1  memory request present (MEM_enable_instr).
- req_rw  in  1  0 = read (load), 1 = write (store).
- req_size  in  1  0 = byte, 1 = word.
- req_addr  in  ADDR_W  byte address (MEM_ALU_out[7:0]).
- req_wdata  in  32  store data (MEM_PD).
- rdata  out  32  load data; valid while done=1.
- done  out  1  one-cycle completion pulse.
- error  out  1  misaligned word access; valid while done=1.
- stall  out  1  to hazard unit; 1 holds PC, IF/ID, ID/EX, EX/MEM and MEM/WB.

## Operation
- Storage: byte array `mem[0:DEPTH-1]`. The bench preloads it hierarchically. Reset does not clear it.
- Word order is big-endian: word at address a = {mem[a], mem[a+1], mem[a+2], mem[a+3]}.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If req_enable=1 at the edge, latch rw, size, addr and wdata, then load cnt=LATENCY.
  - If the request is a misaligned word (size=1, addr[1:0]≠0), go straight to RESP with error=1. No access is performed.
  - Otherwise go to WAIT.
- WAIT:
  - Decrement cnt each edge.
  - On the edge where cnt==1, commit the access and go to RESP.
  - Word write stores all four bytes.
  - Byte write stores only mem[addr] ← wdata[7:0].
  - Word read registers rdata with the big-endian word.
  - Byte read registers rdata = {24'b0, mem[addr]} (zero-extended).
- RESP:
  - done=1 for one cycle; rdata and error are valid.
  - Request inputs are ignored in this state because they still belong to the completed instruction.
  - Next state is IDLE.
- stall = (IDLE && req_enable) || WAIT. It is combinational, so the pipeline freezes in the same cycle the request appears. In RESP, stall=0 and the pipeline advances on that edge with rdata captured into MEM/WB.
- Addressing: word addresses are aligned, so a+3 ≤ DEPTH-1 and never wraps. Any byte address 0..DEPTH-1 is legal.
- rdata holds its last value outside RESP. On a write or error completion, rdata is 0.

## Timing
- Reset (reset=0 at an edge): state=IDLE, cnt=0, rdata=0, done=0, error=0. stall then follows req_enable combinationally.
- Reset mid-operation: a pending access that has not been committed is dropped. A write in WAIT never reaches mem, and no done pulse is produced.
- Latency: request first seen in IDLE at cycle 0; WAIT occupies cycles 1..LATENCY; done at cycle LATENCY+1. stall is high for cycles 0..LATENCY.
- Misaligned word: done=1 and error=1 at cycle 1; stall is high for cycle 0 only.
- Back-to-back requests: the second request is seen in the IDLE cycle after RESP. Minimum spacing is LATENCY+2 cycles between request starts.
- req_enable=0 in IDLE: no state change, stall=0, done=0.

## Test plan
- LATENCY=2, word write addr 0x10 data 0xDEADBEEF, then word read 0x10:
  - stall is high for 3 cycles per access.
  - done rises at cycle 3.
  - rdata=0xDEADBEEF.
  - mem[0x10..0x13] = DE, AD, BE, EF.
- Byte write 0x13 ← 0x0000_00AA, then byte read 0x13 → rdata=0x000000AA. A following word read 0x10 → 0xDEADBEAA.
- Word read at addr 0x22 → done at cycle 1 with error=1 and rdata=0. Memory is unchanged.
- Word write addr 0x40 data 0x12345678 with reset=0 asserted in the first WAIT cycle:
  - done never pulses.
  - mem[0x40..0x43] keeps its preloaded values.
  - All outputs are 0 after reset.
- Two consecutive requests with req_enable held high through RESP: exactly two done pulses, spaced 4 cycles apart for LATENCY=2. The request seen during RESP is not re-executed.
- LATENCY=1 with a word read at 0xFC (preloaded 01 02 03 04): done at cycle 2, rdata=0x01020304, and no address wrap.
